// File: rtl/serial_operand_transmitter_if.sv
// Operand-pair handshake and serial-comparator link for serial_operand_transmitter.
// master = upstream operand source / link observer, slave = the transmitter.
`timescale 1ns/1ps
interface serial_operand_transmitter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ser_clr;
  logic             ser_valid;
  logic             ser_a;
  logic             ser_b;
  logic             ser_last;

  modport master (
    output in_valid, a_in, b_in,
    input  in_ready, ser_clr, ser_valid, ser_a, ser_b, ser_last
  );

  modport slave (
    input  in_valid, a_in, b_in,
    output in_ready, ser_clr, ser_valid, ser_a, ser_b, ser_last
  );
endinterface

// File: rtl/serial_operand_transmitter.sv
// Parallel-to-serial operand transmitter feeding a serial comparator; MSB first by default,
// LSB first when SERIAL_OPERAND_LSB_FIRST_EN is defined.
`timescale 1ns/1ps
module serial_operand_transmitter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_operand_transmitter_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             ser_clr_q, ser_clr_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             ser_a_q, ser_a_d;
  logic             ser_b_q, ser_b_d;
  logic             in_ready_c;
  logic             accept_c;

  // Ready is a pure state decode so upstream can never form a combinational loop through it.
  assign in_ready_c = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST));
  assign accept_c   = bus.in_valid && in_ready_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    ser_clr_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    ser_a_d     = 1'b0;
    ser_b_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = CLEAR;
          sh_a_d  = bus.a_in;
          sh_b_d  = bus.b_in;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + CW'(1);
`ifdef SERIAL_OPERAND_LSB_FIRST_EN
          sh_a_d = sh_a_q >> 1;
          sh_b_d = sh_b_q >> 1;
`else
          sh_a_d = sh_a_q << 1;
          sh_b_d = sh_b_q << 1;
`endif
        end else if (accept_c) begin
          state_d = CLEAR;
          sh_a_d  = bus.a_in;
          sh_b_d  = bus.b_in;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Link outputs are registered: decode the state being entered so they align with it.
    ser_clr_d   = (state_d == CLEAR);
    ser_valid_d = (state_d == SHIFT);
    ser_last_d  = (state_d == SHIFT) && (cnt_d == LAST);
    if (state_d == SHIFT) begin
`ifdef SERIAL_OPERAND_LSB_FIRST_EN
      ser_a_d = sh_a_d[0];
      ser_b_d = sh_b_d[0];
`else
      ser_a_d = sh_a_d[WIDTH-1];
      ser_b_d = sh_b_d[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      ser_clr_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      ser_a_q     <= 1'b0;
      ser_b_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      ser_clr_q   <= ser_clr_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      ser_a_q     <= ser_a_d;
      ser_b_q     <= ser_b_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ser_clr   = ser_clr_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.ser_a     = ser_a_q;
  assign bus.ser_b     = ser_b_q;

  // Clear and data never overlap, and the bit counter stays inside the word.
  a_clr_data_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ser_clr_q && ser_valid_q));
  a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= LAST);
endmodule

// File: tb/tb_serial_operand_transmitter.sv
// Table-driven bench for serial_operand_transmitter (WIDTH=4) plus a hand sequence for WIDTH=1.
`timescale 1ns/1ps
module tb_serial_operand_transmitter;
  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] a;
    logic [3:0] b;
    logic       rdy;
    logic       clr;
    logic       val;
    logic       last;
    logic       sa;
    logic       sb;
    logic       cmp_chk;
    logic       gt;
    logic       eq;
  } vec_t;

  logic clk = 1'b0;
  logic rst4;
  logic rst1;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  serial_operand_transmitter_if #(.WIDTH(4)) bus4 ();
  serial_operand_transmitter_if #(.WIDTH(1)) bus1 ();

  serial_operand_transmitter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
  serial_operand_transmitter #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  // Reference serial comparator attached to the WIDTH=4 link, matching the build's bit order.
  logic cmp_gt_q, cmp_lt_q, cmp_gt_c, cmp_lt_c, cmp_eq_c;
  always_comb begin
    cmp_gt_c = cmp_gt_q;
    cmp_lt_c = cmp_lt_q;
    if (bus4.ser_valid) begin
`ifdef SERIAL_OPERAND_LSB_FIRST_EN
      cmp_gt_c = (bus4.ser_a & ~bus4.ser_b) | (cmp_gt_q & ~(~bus4.ser_a & bus4.ser_b));
      cmp_lt_c = (~bus4.ser_a & bus4.ser_b) | (cmp_lt_q & ~(bus4.ser_a & ~bus4.ser_b));
`else
      cmp_gt_c = cmp_gt_q | (~cmp_lt_q & bus4.ser_a & ~bus4.ser_b);
      cmp_lt_c = cmp_lt_q | (~cmp_gt_q & ~bus4.ser_a & bus4.ser_b);
`endif
    end
    cmp_eq_c = ~cmp_gt_c & ~cmp_lt_c;
  end
  always @(posedge clk) begin
    if (bus4.ser_clr) begin
      cmp_gt_q <= 1'b0;
      cmp_lt_q <= 1'b0;
    end else begin
      cmp_gt_q <= cmp_gt_c;
      cmp_lt_q <= cmp_lt_c;
    end
  end

  function automatic logic obit(input logic [3:0] v, input int k);
    logic [3:0] t;
    t = v;
`ifdef SERIAL_OPERAND_LSB_FIRST_EN
    return t[k];
`else
    return t[3-k];
`endif
  endfunction

  task automatic chk(input string nm, input int row, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %b, expected %b", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                     input logic rdy, input logic clr, input logic val, input logic last,
                     input logic sa, input logic sb,
                     input logic cc, input logic gt, input logic eq);
    vec_t e;
    e.rst = r; e.vld = v; e.a = a; e.b = b;
    e.rdy = rdy; e.clr = clr; e.val = val; e.last = last; e.sa = sa; e.sb = sb;
    e.cmp_chk = cc; e.gt = gt; e.eq = eq;
    vecs.push_back(e);
  endtask

  task automatic add_idle(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    add(r, v, a, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_clr(input logic v, input logic [3:0] a, input logic [3:0] b);
    add(1'b0, v, a, b, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One data-bit cycle of word (wa, wb) at bit position k; the final bit raises ready and last.
  task automatic add_bit(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] wa, input logic [3:0] wb, input int k,
                         input logic cc, input logic gt, input logic eq);
    add(r, v, a, b, 1'(k == 3), 1'b0, 1'b1, 1'(k == 3), obit(wa, k), obit(wb, k), cc, gt, eq);
  endtask

  task automatic chk_w1(input string ctx, input logic rdy, input logic clr, input logic val,
                        input logic last, input logic sa, input logic sb);
    chk({ctx, ".in_ready"},  0, bus1.in_ready,  rdy);
    chk({ctx, ".ser_clr"},   0, bus1.ser_clr,   clr);
    chk({ctx, ".ser_valid"}, 0, bus1.ser_valid, val);
    chk({ctx, ".ser_last"},  0, bus1.ser_last,  last);
    chk({ctx, ".ser_a"},     0, bus1.ser_a,     sa);
    chk({ctx, ".ser_b"},     0, bus1.ser_b,     sb);
  endtask

  initial begin
    logic [3:0] a1, b1, a2, b2, a3, b3, junk_a, junk_b;
    a1 = 4'b1010; b1 = 4'b1001;
    a2 = 4'b0011; b2 = 4'b0011;
    a3 = 4'b0001; b3 = 4'b1000;
    junk_a = 4'b1111; junk_b = 4'b0000;

    // Reset state held over idle cycles.
    for (int i = 0; i < 3; i++) add_idle(1'b0, 1'b0, 4'h0, 4'h0);
    // Basic word, then back-to-back second word with in_valid held high.
    add_idle(1'b0, 1'b1, a1, b1);
    add_clr(1'b1, a2, b2);
    for (int k = 0; k < 4; k++) add_bit(1'b0, 1'b1, a2, b2, a1, b1, k, 1'(k == 3), 1'b1, 1'b0);
    add_clr(1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) add_bit(1'b0, 1'b0, 4'h0, 4'h0, a2, b2, k, 1'(k == 3), 1'b0, 1'b1);
    add_idle(1'b0, 1'b0, 4'h0, 4'h0);
    // Stall: junk offered during clear, valid raised mid-shift, accepted only on the last bit.
    add_idle(1'b0, 1'b1, a1, b1);
    add_clr(1'b1, junk_a, junk_b);
    add_bit(1'b0, 1'b0, junk_a, junk_b, a1, b1, 0, 1'b0, 1'b0, 1'b0);
    add_bit(1'b0, 1'b1, junk_a, junk_b, a1, b1, 1, 1'b0, 1'b0, 1'b0);
    add_bit(1'b0, 1'b1, a2, b2, a1, b1, 2, 1'b0, 1'b0, 1'b0);
    add_bit(1'b0, 1'b1, a2, b2, a1, b1, 3, 1'b1, 1'b1, 1'b0);
    add_clr(1'b0, junk_a, junk_b);
    for (int k = 0; k < 4; k++) add_bit(1'b0, 1'b0, 4'h0, 4'h0, a2, b2, k, 1'(k == 3), 1'b0, 1'b1);
    add_idle(1'b0, 1'b0, 4'h0, 4'h0);
    // Reset mid-word: rst during the second data bit, no ser_last afterwards.
    add_idle(1'b0, 1'b1, a1, b1);
    add_clr(1'b0, 4'h0, 4'h0);
    add_bit(1'b0, 1'b0, 4'h0, 4'h0, a1, b1, 0, 1'b0, 1'b0, 1'b0);
    add_bit(1'b1, 1'b1, a2, b2, a1, b1, 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add_idle(1'b0, 1'b0, 4'h0, 4'h0);
    // Reset coincident with a handshake: word must not be accepted.
    add_idle(1'b1, 1'b1, a1, b1);
    add_idle(1'b0, 1'b0, 4'h0, 4'h0);
    add_idle(1'b0, 1'b0, 4'h0, 4'h0);
    // Bit-order word: a=0001 leaves as 0,0,0,1 MSB-first or 1,0,0,0 LSB-first.
    add_idle(1'b0, 1'b1, a3, b3);
    add_clr(1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) add_bit(1'b0, 1'b0, 4'h0, 4'h0, a3, b3, k, 1'b0, 1'b0, 1'b0);
    add_idle(1'b0, 1'b0, 4'h0, 4'h0);

    rst4 = 1'b1; rst1 = 1'b1;
    bus4.in_valid = 1'b0; bus4.a_in = '0; bus4.b_in = '0;
    bus1.in_valid = 1'b0; bus1.a_in = '0; bus1.b_in = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst4          = vecs[i].rst;
      bus4.in_valid = vecs[i].vld;
      bus4.a_in     = vecs[i].a;
      bus4.b_in     = vecs[i].b;
      #1;
      chk("in_ready",  i, bus4.in_ready,  vecs[i].rdy);
      chk("ser_clr",   i, bus4.ser_clr,   vecs[i].clr);
      chk("ser_valid", i, bus4.ser_valid, vecs[i].val);
      chk("ser_last",  i, bus4.ser_last,  vecs[i].last);
      chk("ser_a",     i, bus4.ser_a,     vecs[i].sa);
      chk("ser_b",     i, bus4.ser_b,     vecs[i].sb);
      if (vecs[i].cmp_chk) begin
        chk("cmp_a_greater_b", i, cmp_gt_c, vecs[i].gt);
        chk("cmp_a_eq_b",      i, cmp_eq_c, vecs[i].eq);
      end
      @(posedge clk);
      #1;
    end

    // WIDTH=1: single-cycle SHIFT with last and ready together, then a back-to-back word.
    rst1 = 1'b0;
    #1;
    chk_w1("w1_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus1.in_valid = 1'b1; bus1.a_in = 1'b1; bus1.b_in = 1'b0;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0; bus1.a_in = 1'b0; bus1.b_in = 1'b1;
    chk_w1("w1_clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_w1("w1_bit", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    chk_w1("w1_b2b_clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_w1("w1_b2b_bit", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_w1("w1_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
